// File: rtl/cu_control_command_arbiter_if.sv
// Command-channel bundle between the CU controls, the arbiter and the AFU command buffer.
interface cu_control_command_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int CMD_W   = 128,
   parameter int ID_W    = 8,
   parameter int CNT_W   = 5
);
   logic                       enabled_in;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*CMD_W-1:0]   req_cmd;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       cmd_out_valid;
   logic [CMD_W-1:0]           cmd_out;
   logic [ID_W-1:0]            cmd_out_cu_id;
   logic                       cmd_out_ready;
   logic                       rsp_valid;
   logic [ID_W-1:0]            rsp_cu_id;
   logic [NUM_REQ*CNT_W-1:0]   outstanding_out;
   logic                       idle_out;
   logic                       error_out;

   modport slave (
      input  enabled_in, req_valid, req_cmd,
      input  cmd_out_ready, rsp_valid, rsp_cu_id,
      output req_ready, cmd_out_valid, cmd_out, cmd_out_cu_id,
      output outstanding_out, idle_out, error_out
   );

   modport master (
      output enabled_in, req_valid, req_cmd,
      output cmd_out_ready, rsp_valid, rsp_cu_id,
      input  req_ready, cmd_out_valid, cmd_out, cmd_out_cu_id,
      input  outstanding_out, idle_out, error_out
   );
endinterface

// File: rtl/cu_control_command_arbiter.sv
// Round-robin CU command arbiter with per-requester credit tracking.
// Optional: CU_ARB_VERTEX_PRIORITY_EN gives requester 0 absolute priority.
module cu_control_command_arbiter #(
   parameter int              NUM_REQ = 4,
   parameter int              CMD_W   = 128,
   parameter int              CREDITS = 16,
   parameter int              ID_W    = 8,
   parameter logic [ID_W-1:0] BASE_ID = 8'd254
) (
   input logic clock,
   input logic rstn,
   cu_control_command_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(CREDITS) + 1;
   localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [CNT_W-1:0] cnt [NUM_REQ];
   logic [PW-1:0]    ptr;
   logic             vld;
   logic [CMD_W-1:0] cmd;
   logic [ID_W-1:0]  cid;
   logic             err;

   logic               free;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] sel;
   logic               gnt;
   logic [PW-1:0]      g;
   logic [PW-1:0]      ptr_nxt;
   logic               ptr_upd;
   logic [ID_W:0]      diff;
   logic               hit;
   logic               unmapped;
   logic [PW-1:0]      j;
   logic               idle;

   always_comb begin
      free = !vld || bus.cmd_out_ready;
      for (int i = 0; i < NUM_REQ; i++)
         elig[i] = bus.req_valid[i] && (cnt[i] < CNT_W'(CREDITS));
      gnt = 1'b0;
      g   = '0;
`ifdef CU_ARB_VERTEX_PRIORITY_EN
      if (elig[0]) begin
         gnt = 1'b1;
         g   = '0;
      end
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!gnt && elig[(int'(ptr) + k) % NUM_REQ]) begin
            gnt = 1'b1;
            g   = PW'((int'(ptr) + k) % NUM_REQ);
         end
      end
      gnt     = gnt && bus.enabled_in && free && rstn;
      sel     = gnt ? (NUM_REQ'(1) << g) : '0;
      ptr_nxt = (int'(g) == NUM_REQ - 1) ? '0 : g + PW'(1);
`ifdef CU_ARB_VERTEX_PRIORITY_EN
      ptr_upd = gnt && (g != '0);
`else
      ptr_upd = gnt;
`endif
      // Response ID maps back to index BASE_ID - id when it lies in range
      diff     = {1'b0, BASE_ID} - {1'b0, bus.rsp_cu_id};
      hit      = bus.rsp_valid && !diff[ID_W]
                 && (diff < (ID_W+1)'(NUM_REQ));
      unmapped = bus.rsp_valid && !hit;
      j        = diff[PW-1:0];
      idle     = !vld;
      for (int i = 0; i < NUM_REQ; i++)
         if (cnt[i] != '0) idle = 1'b0;
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         ptr <= '0;
         vld <= 1'b0;
         cmd <= '0;
         cid <= '0;
         err <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++)
            cnt[i] <= '0;
      end else begin
         if (gnt) begin
            vld <= 1'b1;
            cmd <= bus.req_cmd[int'(g)*CMD_W +: CMD_W];
            cid <= BASE_ID - ID_W'(g);
         end else if (free) begin
            vld <= 1'b0;
         end
         if (ptr_upd)
            ptr <= ptr_nxt;
         for (int i = 0; i < NUM_REQ; i++) begin
            logic dec;
            dec = hit && (int'(j) == i) && (cnt[i] != '0);
            if (sel[i] && !dec)
               cnt[i] <= cnt[i] + CNT_W'(1);
            else if (!sel[i] && dec)
               cnt[i] <= cnt[i] - CNT_W'(1);
         end
         if (unmapped || (hit && cnt[j] == '0))
            err <= 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         bus.outstanding_out[i*CNT_W +: CNT_W] = cnt[i];
   end

   assign bus.req_ready     = sel;
   assign bus.cmd_out_valid = vld;
   assign bus.cmd_out       = cmd;
   assign bus.cmd_out_cu_id = cid;
   assign bus.idle_out      = idle;
   assign bus.error_out     = err;
endmodule

// File: tb/tb_cu_control_command_arbiter.sv
// Randomized and directed bench for cu_control_command_arbiter
// checked against a cycle-level reference model of the arbitration rules.
module tb_cu_control_command_arbiter;
   logic clock = 1'b0;
   logic rstn  = 1'b0;

   cu_control_command_arbiter_if bus ();

   cu_control_command_arbiter dut (
      .clock(clock),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   int           m_cnt [4];
   int           m_ptr;
   logic         m_ov;
   logic [127:0] m_cmd;
   int           m_id;
   logic         m_err;
   logic [127:0] pay [4];

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] v, input logic rdy,
                               input logic en);
      if (!en || !(!m_ov || rdy)) return -1;
`ifdef CU_ARB_VERTEX_PRIORITY_EN
      if (v[0] && m_cnt[0] < 16) return 0;
`endif
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (m_ptr + k) % 4;
         if (v[i] && m_cnt[i] < 16) return i;
      end
      return -1;
   endfunction

   task automatic check_state();
      chk("valid", bus.cmd_out_valid, m_ov);
      if (m_ov) begin
         chk("cu_id", bus.cmd_out_cu_id, m_id);
         chk("cmd", bus.cmd_out, m_cmd);
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("outst%0d", i), bus.outstanding_out[i*5 +: 5],
             m_cnt[i]);
      chk("idle", bus.idle_out,
          (!m_ov && m_cnt[0] == 0 && m_cnt[1] == 0
           && m_cnt[2] == 0 && m_cnt[3] == 0));
      chk("error", bus.error_out, m_err);
   endtask

   task automatic cyc(input logic [3:0] v, input logic rdy, input logic en,
                      input logic rv, input logic [7:0] rid);
      int gsel;
      @(negedge clock);
      for (int i = 0; i < 4; i++)
         pay[i] = {$urandom, $urandom, $urandom, $urandom};
      bus.req_cmd       = {pay[3], pay[2], pay[1], pay[0]};
      bus.req_valid     = v;
      bus.cmd_out_ready = rdy;
      bus.enabled_in    = en;
      bus.rsp_valid     = rv;
      bus.rsp_cu_id     = rid;
      #1;
      gsel = pick(v, rdy, en);
      chk("req_ready", bus.req_ready, (gsel >= 0) ? (4'b1 << gsel) : 4'b0);
      check_state();
      @(posedge clock);
      if (rv) begin
         if (rid > 254 || (254 - int'(rid)) > 3) m_err = 1'b1;
         else if (m_cnt[254 - int'(rid)] == 0) m_err = 1'b1;
         else m_cnt[254 - int'(rid)]--;
      end
      if (gsel >= 0) begin
         m_ov  = 1'b1;
         m_cmd = pay[gsel];
         m_id  = 254 - gsel;
         m_cnt[gsel]++;
`ifdef CU_ARB_VERTEX_PRIORITY_EN
         if (gsel != 0) m_ptr = (gsel + 1) % 4;
`else
         m_ptr = (gsel + 1) % 4;
`endif
      end else if (!m_ov || rdy) begin
         m_ov = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      rstn = 1'b0;
      #1;
      m_ptr = 0;
      m_ov  = 1'b0;
      m_cmd = '0;
      m_id  = 0;
      m_err = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      chk("rst_ready", bus.req_ready, 4'b0);
      chk("rst_cu_id", bus.cmd_out_cu_id, 8'd0);
      chk("rst_cmd", bus.cmd_out, 128'd0);
      check_state();
      bus.req_valid = '0;
      bus.rsp_valid = 1'b0;
      @(negedge clock);
      rstn = 1'b1;
   endtask

   initial begin
      bus.enabled_in    = 1'b1;
      bus.req_valid     = 4'hF;
      bus.req_cmd       = '0;
      bus.cmd_out_ready = 1'b1;
      bus.rsp_valid     = 1'b0;
      bus.rsp_cu_id     = '0;
      do_reset();

      // round-robin over all four
      repeat (6) cyc(4'hF, 1'b1, 1'b1, 1'b0, 8'd0);

      // backpressure while holding requester 2
      do_reset();
      cyc(4'b0100, 1'b1, 1'b1, 1'b0, 8'd0);
      repeat (5) cyc(4'hF, 1'b0, 1'b1, 1'b0, 8'd0);
      repeat (3) cyc(4'hF, 1'b1, 1'b1, 1'b0, 8'd0);

      // credit exhaustion on requester 1
      do_reset();
      repeat (17) cyc(4'b0010, 1'b1, 1'b1, 1'b0, 8'd0);
      #1;
      chk("credit_full", bus.outstanding_out[5 +: 5], 5'd16);
      cyc(4'b0010, 1'b1, 1'b1, 1'b1, 8'd253);
      repeat (2) cyc(4'b0010, 1'b1, 1'b1, 1'b0, 8'd0);

      // grant and response on the same index
      do_reset();
      repeat (3) cyc(4'b0001, 1'b1, 1'b1, 1'b0, 8'd0);
      cyc(4'b0001, 1'b1, 1'b1, 1'b1, 8'd254);
      #1;
      chk("same_idx", bus.outstanding_out[0 +: 5], 5'd3);

      // unmapped id and underflow
      do_reset();
      cyc(4'b0000, 1'b1, 1'b1, 1'b1, 8'd200);
      #1;
      chk("err_unmapped", bus.error_out, 1'b1);
      do_reset();
      cyc(4'b0000, 1'b1, 1'b1, 1'b1, 8'd252);
      cyc(4'b0000, 1'b1, 1'b0, 1'b0, 8'd0);
      do_reset();

      // randomized traffic with a mid-run reset
      for (int n = 0; n < 600; n++) begin
         logic [7:0] rid;
         if (n == 300) do_reset();
         rid = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                           : 8'(251 + $urandom_range(0, 3));
         cyc(4'($urandom), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 9) != 0), ($urandom_range(0, 1) == 1), rid);
      end

      // drain all credits back
      for (int i = 0; i < 4; i++)
         while (m_cnt[i] > 0) cyc(4'b0, 1'b1, 1'b1, 1'b1, 8'(254 - i));
      cyc(4'b0, 1'b1, 1'b1, 1'b0, 8'd0);
      #1;
      chk("final_idle", bus.idle_out, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cu_control_command_arbiter.md
Name: cu_control_command_arbiter

Overview:
- Shares one CU-control command channel among NUM_REQ command generators: vertex control, edge-data-read control, edge-data-write control and prefetch control, in index order 0..3.
- Arbitrates round-robin and stamps each command with the requester's CU ID. Requester i has ID BASE_ID - i, so the descending ID chain matches the control-ID assignment.
- Tracks outstanding commands per requester with credit counters that are returned by responses.
- Sits between the per-unit controls and the AFU command buffer.

Parameters:
- NUM_REQ, 4, number of requesters.
- CMD_W, 128, command payload width in bits.
- CREDITS, 16, maximum outstanding commands per requester.
- ID_W, 8, CU ID width.
- BASE_ID, 8'd254, ID of requester 0; requester i uses BASE_ID - i.

Ports:
- clock  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- enabled_in  in  1  grant enable.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_cmd  in  NUM_REQ*CMD_W  payloads; requester i occupies bits [i*CMD_W +: CMD_W].
- req_ready  out  NUM_REQ  one-hot accept (combinational).
- cmd_out_valid  out  1  registered command valid.
- cmd_out  out  CMD_W  registered payload.
- cmd_out_cu_id  out  ID_W  registered ID of the granted requester.
- cmd_out_ready  in  1  downstream accept.
- rsp_valid  in  1  response returns one credit.
- rsp_cu_id  in  ID_W  ID the response belongs to.
- outstanding_out  out  NUM_REQ*($clog2(CREDITS)+1)  per-requester outstanding count.
- idle_out  out  1  all outstanding counts are 0 and cmd_out_valid=0.
- error_out  out  1  sticky credit-underflow/unknown-ID flag.

Behaviour:
- Reset (rstn low, asynchronous) clears cmd_out_valid, cmd_out, cmd_out_cu_id, all outstanding counts and error_out. The RR pointer resets to 0. idle_out=1. req_ready=0.
- Reset mid-operation drops any held command; credits are not replayed.
- Output register is "free" when cmd_out_valid=0 or cmd_out_ready=1.
- Eligible(i) = req_valid[i] && outstanding[i] < CREDITS.
- Grant condition: enabled_in=1, output register free, at least one eligible requester.
- Grant selection: first eligible requester searching from ptr, ptr+1, ..., wrapping modulo NUM_REQ.
- On grant to requester g:
  - req_ready[g]=1 in the same cycle; all other req_ready bits are 0.
  - Next edge loads cmd_out=req_cmd[g], cmd_out_cu_id=BASE_ID-g, cmd_out_valid=1.
  - ptr becomes (g+1) mod NUM_REQ.
  - outstanding[g] increments.
- No grant while the register is free: cmd_out_valid clears at the next edge if it is currently being drained. ptr is unchanged.
- Latency: request to cmd_out_valid is 1 cycle. Throughput is 1 command per cycle while cmd_out_ready=1.
- Backpressure: while cmd_out_valid=1 and cmd_out_ready=0, cmd_out and cmd_out_cu_id are held stable and no grants occur.
- enabled_in=0 blocks new grants only. A held command still drains. Responses are still accepted.
- Responses: when rsp_valid=1 and rsp_cu_id maps to index j in 0..NUM_REQ-1, outstanding[j] decrements.
- Simultaneous grant and response on the same index: count unchanged.
- Response at count 0: count stays 0 and error_out sets.
- Response with an unmapped ID: ignored and error_out sets.
- error_out clears only on reset.
- Credit full: a requester at CREDITS is skipped. The search continues to the next eligible requester, so there is no stall of the others.
- Counters are CREDITS-width+1 unsigned and never wrap.

Optional Feature:
- Macro: CU_ARB_VERTEX_PRIORITY_EN.
- Defined: requester 0 (vertex control) wins whenever it is eligible, regardless of ptr. ptr updates only on grants to requesters 1..NUM_REQ-1, which are round-robined among themselves.
- Not defined: pure round-robin over all requesters as above.

Test Plan:
- Reset then all four req_valid=1, cmd_out_ready=1, no responses -> grants in order 0,1,2,3,0,...; cmd_out_cu_id 254,253,252,251,254; cmd_out_valid rises 1 cycle after the first req_ready.
- Grant requester 2, then hold cmd_out_ready=0 for 5 cycles -> cmd_out/cmd_out_cu_id=252 stable, all req_ready=0; grants resume on the cycle cmd_out_ready=1.
- Requester 1 alone issues 16 commands with no responses -> outstanding[1]=16, the 17th is not accepted; one rsp with ID 253 -> the next grant is accepted on the following cycle.
- Grant to 0 and rsp_cu_id=254 in the same cycle with outstanding[0]=3 -> outstanding[0] stays 3.
- rsp_cu_id=200 or a response to an index with count 0 -> counts unchanged, error_out=1 until rstn is pulsed low.
- With CU_ARB_VERTEX_PRIORITY_EN and requesters 0 and 3 both valid continuously -> only 0 is granted until outstanding[0]=16, then 3; idle_out=1 after all credits return.
